// File: rtl/snake_pkg.sv
// Shared snake-game constants: FSM encodings, screen limits, LFSR taps and coordinate fold.
// Used by the game controller, the LFSR and the VGA renderer.
package snake_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_PLAY    = 2'd1;
    localparam state_t ST_OVER    = 2'd2;
    localparam state_t ST_RESTART = 2'd3;

    localparam logic [9:0] H_MAX_DEF = 10'd799;
    localparam logic [9:0] V_MAX_DEF = 10'd599;

    localparam int LFSR_W      = 20;
    localparam int LFSR_TAP_HI = 19;
    localparam int LFSR_TAP_LO = 16;

    // Values above lim wrap down by (1023-lim); lands in range as long as lim >= 511.
    function automatic logic [9:0] fold_coord(input logic [9:0] c, input logic [9:0] lim);
        return (c > lim) ? (c - (10'd1023 - lim)) : c;
    endfunction

endpackage

// File: rtl/snake_lfsr20.sv
// Free-running 20-bit Fibonacci LFSR with on-screen x/y fold.
// Latency: x/y are combinational from the LFSR register; no backpressure, shifts every cycle.
module snake_lfsr20
    import snake_pkg::*;
#(
    parameter logic [19:0] SEED  = 20'hACE1B,
    parameter logic [9:0]  H_MAX = H_MAX_DEF,
    parameter logic [9:0]  V_MAX = V_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] x,
    output logic [9:0] y
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign x = fold_coord(lfsr_q[9:0], H_MAX);
    assign y = fold_coord(lfsr_q[19:10], V_MAX);

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: FSM, step timer, score, speed-up and food placement.
// Latency: all outputs registered, 1 cycle after start/drive/fin; no backpressure.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter logic [9:0]  H_MAX     = H_MAX_DEF,
    parameter logic [9:0]  V_MAX     = V_MAX_DEF,
    parameter logic [18:0] STEP_INIT = 19'd312500,
    parameter logic [18:0] STEP_MIN  = 19'd100000,
    parameter logic [18:0] STEP_DEC  = 19'd12500,
    parameter logic [19:0] LFSR_SEED = 20'hACE1B,
    parameter int unsigned RST_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_n,
    input  logic       drive,
    input  logic       fin,
    output logic       step_en,
    output logic [9:0] box_x,
    output logic [9:0] box_y,
    output logic       box_valid,
    output logic [7:0] score,
    output logic [1:0] state,
    output logic       snake_rst_n
);

    localparam logic [3:0]  RST_LAST  = 4'(RST_CYC - 1);
    localparam logic [18:0] DEC_FLOOR = STEP_MIN + STEP_DEC;

    state_t      state_q, state_d;
    logic        start_q, start_d;
    logic [18:0] cnt_q, cnt_d;
    logic [18:0] period_q, period_d;
    logic [7:0]  score_q, score_d;
    logic [9:0]  box_x_q, box_x_d;
    logic [9:0]  box_y_q, box_y_d;
    logic        box_valid_q, box_valid_d;
    logic        step_en_q, step_en_d;
    logic        snake_rst_n_q, snake_rst_n_d;
    logic [3:0]  rst_cnt_q, rst_cnt_d;

    logic [9:0]  cand_x;
    logic [9:0]  cand_y;
    logic        start;
    logic        place;

    snake_lfsr20 #(
        .SEED  (LFSR_SEED),
        .H_MAX (H_MAX),
        .V_MAX (V_MAX)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (cand_x),
        .y     (cand_y)
    );

    always_comb begin
        start         = start_q & ~start_n;
        start_d       = start_n;
        state_d       = state_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        score_d       = score_q;
        box_valid_d   = box_valid_q;
        step_en_d     = 1'b0;
        snake_rst_n_d = 1'b1;
        rst_cnt_d     = rst_cnt_q;
        place         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    score_d  = 8'd0;
                    period_d = STEP_INIT;
                    cnt_d    = 19'd0;
                    place    = 1'b1;
                    state_d  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                box_valid_d = 1'b1;
                if (drive) begin
                    score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                end
                // Death wins over an eat in the same cycle: score counts, food stays put.
                if (fin) begin
                    state_d = ST_OVER;
                end else if (drive) begin
                    period_d = (period_q >= DEC_FLOOR) ? period_q - STEP_DEC : STEP_MIN;
                    place    = 1'b1;
                end else if (cnt_q >= period_q) begin
                    step_en_d = 1'b1;
                    cnt_d     = 19'd0;
                end else begin
                    cnt_d = cnt_q + 19'd1;
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_d       = ST_RESTART;
                    cnt_d         = 19'd0;
                    rst_cnt_d     = 4'd0;
                    snake_rst_n_d = 1'b0;
                    box_valid_d   = 1'b0;
                end
            end
            ST_RESTART: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d     = rst_cnt_q + 4'd1;
                    snake_rst_n_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Food coordinates change only on placement and are flagged invalid for that cycle.
        box_x_d = place ? cand_x : box_x_q;
        box_y_d = place ? cand_y : box_y_q;
        if (place) begin
            box_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            start_q       <= 1'b1;
            cnt_q         <= 19'd0;
            period_q      <= STEP_INIT;
            score_q       <= 8'd0;
            box_x_q       <= 10'd0;
            box_y_q       <= 10'd0;
            box_valid_q   <= 1'b0;
            step_en_q     <= 1'b0;
            snake_rst_n_q <= 1'b0;
            rst_cnt_q     <= 4'd0;
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            score_q       <= score_d;
            box_x_q       <= box_x_d;
            box_y_q       <= box_y_d;
            box_valid_q   <= box_valid_d;
            step_en_q     <= step_en_d;
            snake_rst_n_q <= snake_rst_n_d;
            rst_cnt_q     <= rst_cnt_d;
        end
    end

    assign step_en     = step_en_q;
    assign box_x       = box_x_q;
    assign box_y       = box_y_q;
    assign box_valid   = box_valid_q;
    assign score       = score_q;
    assign state       = state_q;
    assign snake_rst_n = snake_rst_n_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl with shortened step periods (20/8/4).
module tb_snake_game_ctrl;

    localparam logic [19:0] SEED = 20'hACE1B;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       start_n = 1'b1;
    logic       drive   = 1'b0;
    logic       fin     = 1'b0;
    logic       step_en;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic       box_valid;
    logic [7:0] score;
    logic [1:0] state;
    logic       snake_rst_n;

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    logic [19:0] m_lfsr;

    snake_game_ctrl #(
        .STEP_INIT (19'd20),
        .STEP_MIN  (19'd8),
        .STEP_DEC  (19'd4),
        .LFSR_SEED (SEED)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_n     (start_n),
        .drive       (drive),
        .fin         (fin),
        .step_en     (step_en),
        .box_x       (box_x),
        .box_y       (box_y),
        .box_valid   (box_valid),
        .score       (score),
        .state       (state),
        .snake_rst_n (snake_rst_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference LFSR: x^20 + x^17 Fibonacci, shifting every cycle out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[18:0], m_lfsr[19] ^ m_lfsr[16]};
    end

    function automatic logic [9:0] exp_x(input logic [19:0] l);
        logic [9:0] c = l[9:0];
        return (c > 10'd799) ? c - 10'd224 : c;
    endfunction

    function automatic logic [9:0] exp_y(input logic [19:0] l);
        logic [9:0] c = l[19:10];
        return (c > 10'd599) ? c - 10'd424 : c;
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(output int t);
        int n = 0;
        do begin
            tick();
            n++;
        end while (step_en !== 1'b1 && n < 200);
        check("step_seen", step_en, 1);
        t = cyc;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_step_en"}, step_en, 0);
        check({tag, "_box_x"}, box_x, 0);
        check({tag, "_box_y"}, box_y, 0);
        check({tag, "_box_valid"}, box_valid, 0);
        check({tag, "_score"}, score, 0);
        check({tag, "_snake_rst_n"}, snake_rst_n, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, t1, t2;
        logic [19:0] pre;

        // Reset values, then snake_rst_n releases on the first clock.
        repeat (3) tick();
        check_reset_vals("rst");
        rst_n = 1'b1;
        tick();
        check("rel_snake_rst_n", snake_rst_n, 1);
        check("rel_state", state, 0);

        // Start: placement from the LFSR, box_valid one cycle later, 21-cycle ticks.
        start_n = 1'b0;
        pre = m_lfsr;
        tick();
        t0 = cyc;
        check("start_state", state, 1);
        check("start_valid0", box_valid, 0);
        check("start_box_x", box_x, exp_x(pre));
        check("start_box_y", box_y, exp_y(pre));
        tick();
        check("start_valid1", box_valid, 1);
        tick();
        start_n = 1'b1;
        wait_step(t1);
        check("first_tick", t1 - t0, 21);
        wait_step(t2);
        check("tick_gap20", t2 - t1, 21);

        // Four eats in a row: score 1..4, period 20->16->12->8.
        for (int i = 1; i <= 4; i++) begin
            drive = 1'b1;
            pre = m_lfsr;
            tick();
            drive = 1'b0;
            check("eat_score", score, i);
            check("eat_valid0", box_valid, 0);
            check("eat_box_x", box_x, exp_x(pre));
            check("eat_box_y", box_y, exp_y(pre));
            check("eat_no_step", step_en, 0);
        end
        t0 = cyc;
        wait_step(t1);
        check("tick_after_eat", t1 - t0, 9);
        wait_step(t2);
        check("tick_gap8", t2 - t1, 9);

        // Fold boundaries with the LFSR forced at the placement edge.
        force dut.u_lfsr.lfsr_q = 20'hFFFFF;
        drive = 1'b1;
        tick();
        release dut.u_lfsr.lfsr_q;
        drive = 1'b0;
        check("fold_max_x", box_x, 799);
        check("fold_max_y", box_y, 599);
        force dut.u_lfsr.lfsr_q = 20'h003FF;
        drive = 1'b1;
        tick();
        release dut.u_lfsr.lfsr_q;
        drive = 1'b0;
        check("fold_lo_x", box_x, 799);
        check("fold_lo_y", box_y, 0);
        check("fold_score", score, 6);
        t0 = cyc;
        wait_step(t1);
        check("tick_floor", t1 - t0, 9);

        // Eat and death together: score counts, no placement, OVER next.
        drive = 1'b1;
        fin = 1'b1;
        tick();
        drive = 1'b0;
        check("fin_score", score, 7);
        check("fin_state", state, 2);
        check("fin_box_x", box_x, 799);
        check("fin_box_y", box_y, 0);
        check("fin_no_step", step_en, 0);
        drive = 1'b1;
        tick();
        drive = 1'b0;
        check("over_score_hold", score, 7);
        check("over_no_step", step_en, 0);
        check("over_state", state, 2);
        fin = 1'b0;

        // Restart: snake_rst_n low exactly 4 cycles; start during RESTART ignored.
        start_n = 1'b0;
        tick();
        check("restart_valid0", box_valid, 0);
        for (int k = 0; k < 6; k++) begin
            check("rs_state", state, (k < 4) ? 3 : 0);
            check("rs_snake_rst_n", snake_rst_n, (k < 4) ? 0 : 1);
            start_n = (k == 0) ? 1'b1 : 1'b0;
            tick();
        end
        check("idle_no_repeat", state, 0);
        start_n = 1'b1;
        tick();
        start_n = 1'b0;
        tick();
        t0 = cyc;
        start_n = 1'b1;
        check("restart_score", score, 0);
        check("restart_state", state, 1);
        wait_step(t1);
        check("restart_period", t1 - t0, 21);

        // 256 eats: score saturates at 255.
        drive = 1'b1;
        repeat (255) tick();
        check("sat_255", score, 255);
        tick();
        drive = 1'b0;
        check("sat_hold", score, 255);
        check("sat_no_step", step_en, 0);

        // Async reset with a tick pending.
        wait_step(t1);
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        tick();
        tick();
        check("midrst_no_step", step_en, 0);
        rst_n = 1'b1;
        tick();
        check("midrst_rel", snake_rst_n, 1);

        // Fresh start after reset: placement back in step with the reference LFSR.
        start_n = 1'b0;
        pre = m_lfsr;
        tick();
        start_n = 1'b1;
        check("post_box_x", box_x, exp_x(pre));
        check("post_box_y", box_y, exp_y(pre));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
